// File: rtl/add_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// add_arbiter: two-requester round-robin front end for a shared LAT-cycle adder.
// Revision 1.0
// ----------------------------------------------------------------------------
module add_arbiter #(
   parameter int WIDTH = 32,
   parameter int LAT   = 1
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,

   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_s,
   input  logic             add_cout,

   output logic             rsp0_valid,
   output logic [WIDTH-1:0] rsp0_sum,
   output logic             rsp0_cout,

   output logic             rsp1_valid,
   output logic [WIDTH-1:0] rsp1_sum,
   output logic             rsp1_cout,

   output logic             busy
);

   logic             prio_q, prio_d;
   logic [WIDTH-1:0] add_a_q, add_a_d;
   logic [WIDTH-1:0] add_b_q, add_b_d;
   logic             add_cin_q, add_cin_d;
   logic [LAT-1:0]   trk_v_q, trk_v_d;
   logic [LAT-1:0]   trk_tag_q, trk_tag_d;
   logic             rsp0_valid_q, rsp0_valid_d;
   logic             rsp1_valid_q, rsp1_valid_d;
   logic [WIDTH-1:0] rsp0_sum_q, rsp0_sum_d;
   logic [WIDTH-1:0] rsp1_sum_q, rsp1_sum_d;
   logic             rsp0_cout_q, rsp0_cout_d;
   logic             rsp1_cout_q, rsp1_cout_d;

   logic             grant0;
   logic             grant1;
   logic             xfer;
   logic             ret_v;
   logic             ret_tag;

   // Grants are gated by rst_n so ready stays low while reset is asserted.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_n) begin
         if (req0_valid && req1_valid) begin
            grant0 = ~prio_q;
            grant1 = prio_q;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   assign xfer    = grant0 | grant1;
   assign ret_v   = trk_v_q[LAT-1];
   assign ret_tag = trk_tag_q[LAT-1];

   always_comb begin
      prio_d       = prio_q;
      add_a_d      = add_a_q;
      add_b_d      = add_b_q;
      add_cin_d    = add_cin_q;
      trk_v_d      = '0;
      trk_tag_d    = '0;
      rsp0_sum_d   = rsp0_sum_q;
      rsp0_cout_d  = rsp0_cout_q;
      rsp1_sum_d   = rsp1_sum_q;
      rsp1_cout_d  = rsp1_cout_q;

      if (xfer) begin
         // Pointer moves to the requester that was not served.
         prio_d    = grant0;
         add_a_d   = grant1 ? req1_a   : req0_a;
         add_b_d   = grant1 ? req1_b   : req0_b;
         add_cin_d = grant1 ? req1_cin : req0_cin;
      end

      trk_v_d[0]   = xfer;
      trk_tag_d[0] = grant1;
      for (int i = 1; i < LAT; i++) begin
         trk_v_d[i]   = trk_v_q[i-1];
         trk_tag_d[i] = trk_tag_q[i-1];
      end

      rsp0_valid_d = ret_v & ~ret_tag;
      rsp1_valid_d = ret_v &  ret_tag;
      if (rsp0_valid_d) begin
         rsp0_sum_d  = add_s;
         rsp0_cout_d = add_cout;
      end
      if (rsp1_valid_d) begin
         rsp1_sum_d  = add_s;
         rsp1_cout_d = add_cout;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q       <= 1'b0;
         add_a_q      <= '0;
         add_b_q      <= '0;
         add_cin_q    <= 1'b0;
         trk_v_q      <= '0;
         trk_tag_q    <= '0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_sum_q   <= '0;
         rsp1_sum_q   <= '0;
         rsp0_cout_q  <= 1'b0;
         rsp1_cout_q  <= 1'b0;
      end else begin
         prio_q       <= prio_d;
         add_a_q      <= add_a_d;
         add_b_q      <= add_b_d;
         add_cin_q    <= add_cin_d;
         trk_v_q      <= trk_v_d;
         trk_tag_q    <= trk_tag_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp0_sum_q   <= rsp0_sum_d;
         rsp1_sum_q   <= rsp1_sum_d;
         rsp0_cout_q  <= rsp0_cout_d;
         rsp1_cout_q  <= rsp1_cout_d;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign add_a      = add_a_q;
   assign add_b      = add_b_q;
   assign add_cin    = add_cin_q;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp0_sum   = rsp0_sum_q;
   assign rsp0_cout  = rsp0_cout_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp1_sum   = rsp1_sum_q;
   assign rsp1_cout  = rsp1_cout_q;
   assign busy       = (|trk_v_q) | rsp0_valid_q | rsp1_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_add_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_add_arbiter: one stimulus stream drives a LAT=1 and a LAT=3 add_arbiter.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_add_arbiter;

   localparam int c_width = 32;

   typedef struct packed {
      logic               r0;
      logic               r1;
      logic               v0;
      logic               v1;
      logic               c0;
      logic               c1;
      logic               busy;
      logic               cin;
      logic [c_width-1:0] a;
      logic [c_width-1:0] b;
      logic [c_width-1:0] s0;
      logic [c_width-1:0] s1;
   } obs_t;

   typedef struct {
      int                 e;
      bit                 tag;
      logic [c_width-1:0] a;
      logic [c_width-1:0] b;
      logic               cin;
      logic [c_width-1:0] s;
      logic               c;
   } xfer_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic r0v = 1'b0, r1v = 1'b0, r0c = 1'b0, r1c = 1'b0;
   logic [c_width-1:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0;

   logic rdy0_1, rdy1_1, cin_1, v0_1, v1_1, c0_1, c1_1, busy_1, co_1;
   logic rdy0_3, rdy1_3, cin_3, v0_3, v1_3, c0_3, c1_3, busy_3, co_3;
   logic [c_width-1:0] a_1, b_1, s0_1, s1_1, sum_1;
   logic [c_width-1:0] a_3, b_3, s0_3, s1_3, sum_3;
   logic [c_width:0]   raw_1, raw_3, p1 = '0, p2 = '0;
   obs_t o1, o3;

   always #5 clk = ~clk;

   add_arbiter #(.WIDTH(c_width), .LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(r0v), .req0_ready(rdy0_1), .req0_a(r0a), .req0_b(r0b), .req0_cin(r0c),
      .req1_valid(r1v), .req1_ready(rdy1_1), .req1_a(r1a), .req1_b(r1b), .req1_cin(r1c),
      .add_a(a_1), .add_b(b_1), .add_cin(cin_1), .add_s(sum_1), .add_cout(co_1),
      .rsp0_valid(v0_1), .rsp0_sum(s0_1), .rsp0_cout(c0_1),
      .rsp1_valid(v1_1), .rsp1_sum(s1_1), .rsp1_cout(c1_1),
      .busy(busy_1)
   );

   add_arbiter #(.WIDTH(c_width), .LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(r0v), .req0_ready(rdy0_3), .req0_a(r0a), .req0_b(r0b), .req0_cin(r0c),
      .req1_valid(r1v), .req1_ready(rdy1_3), .req1_a(r1a), .req1_b(r1b), .req1_cin(r1c),
      .add_a(a_3), .add_b(b_3), .add_cin(cin_3), .add_s(sum_3), .add_cout(co_3),
      .rsp0_valid(v0_3), .rsp0_sum(s0_3), .rsp0_cout(c0_3),
      .rsp1_valid(v1_3), .rsp1_sum(s1_3), .rsp1_cout(c1_3),
      .busy(busy_3)
   );

   // Shared adders: combinational for LAT=1, two register stages for LAT=3.
   assign raw_1          = {1'b0, a_1} + {1'b0, b_1} + {{c_width{1'b0}}, cin_1};
   assign {co_1, sum_1}  = raw_1;
   assign raw_3          = {1'b0, a_3} + {1'b0, b_3} + {{c_width{1'b0}}, cin_3};
   always @(posedge clk) begin
      p1 <= raw_3;
      p2 <= p1;
   end
   assign {co_3, sum_3}  = p2;

   assign o1 = {rdy0_1, rdy1_1, v0_1, v1_1, c0_1, c1_1, busy_1, cin_1, a_1, b_1, s0_1, s1_1};
   assign o3 = {rdy0_3, rdy1_3, v0_3, v1_3, c0_3, c1_3, busy_3, cin_3, a_3, b_3, s0_3, s1_3};

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
      end
   endtask

   // Transaction model: every transfer is logged with its edge number; a
   // response is due LAT edges later, and per-instance read pointers walk the log.
   xfer_t              q[$];
   int                 rd[2] = '{0, 0};
   bit                 m_prio = 1'b0;
   logic [c_width-1:0] m_a = '0, m_b = '0;
   logic               m_cin = 1'b0;
   logic [c_width-1:0] m_s0[2], m_s1[2];
   logic               m_c0[2], m_c1[2];
   int                 rlog_a[$], rlog_b[$], plog[$];

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_s0[k] = '0; m_s1[k] = '0; m_c0[k] = 1'b0; m_c1[k] = 1'b0;
      end
   end

   always @(negedge clk) begin
      obs_t  o[2];
      bit    e_r0, e_r1, due, eb;
      int    lat;
      xfer_t x;
      o[0] = o1;
      o[1] = o3;
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("i%0d_reset_zero", k), o[k], '0);
            rd[k] = q.size();
            m_s0[k] = '0; m_s1[k] = '0; m_c0[k] = 1'b0; m_c1[k] = 1'b0;
         end
         m_prio = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0;
      end else begin
         e_r0 = r0v && (!r1v || !m_prio);
         e_r1 = r1v && (!r0v ||  m_prio);
         for (int k = 0; k < 2; k++) begin
            lat = (k == 0) ? 1 : 3;
            due = (rd[k] < q.size()) && (q[rd[k]].e + lat == cyc);
            eb  = (rd[k] < q.size()) && (q[rd[k]].e <= cyc);
            if (due) begin
               if (q[rd[k]].tag) begin m_s1[k] = q[rd[k]].s; m_c1[k] = q[rd[k]].c; end
               else              begin m_s0[k] = q[rd[k]].s; m_c0[k] = q[rd[k]].c; end
            end
            chk($sformatf("i%0d_ready0", k), o[k].r0, e_r0);
            chk($sformatf("i%0d_ready1", k), o[k].r1, e_r1);
            chk($sformatf("i%0d_rsp0_valid", k), o[k].v0, due && !q[rd[k]].tag);
            chk($sformatf("i%0d_rsp1_valid", k), o[k].v1, due &&  q[rd[k]].tag);
            chk($sformatf("i%0d_busy", k), o[k].busy, eb);
            chk($sformatf("i%0d_add_ops", k), {o[k].a, o[k].b, o[k].cin}, {m_a, m_b, m_cin});
            chk($sformatf("i%0d_rsp0_data", k), {o[k].s0, o[k].c0}, {m_s0[k], m_c0[k]});
            chk($sformatf("i%0d_rsp1_data", k), {o[k].s1, o[k].c1}, {m_s1[k], m_c1[k]});
            if (due) rd[k]++;
         end
         if (v0_1) rlog_a.push_back(0);
         if (v1_1) rlog_a.push_back(1);
         if (v0_3) rlog_b.push_back(0);
         if (v1_3) rlog_b.push_back(1);
         if (v1_3) plog.push_back(cyc);
         if (e_r0 || e_r1) begin
            x.e   = cyc + 1;
            x.tag = e_r1;
            x.a   = e_r1 ? r1a : r0a;
            x.b   = e_r1 ? r1b : r0b;
            x.cin = e_r1 ? r1c : r0c;
            {x.c, x.s} = {1'b0, x.a} + {1'b0, x.b} + {{c_width{1'b0}}, x.cin};
            q.push_back(x);
            m_a = x.a; m_b = x.b; m_cin = x.cin;
            m_prio = e_r0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [c_width-1:0] tab_a[4] = '{32'h0000_0010, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0000_0001};
   logic [c_width-1:0] tab_b[4] = '{32'h0000_0020, 32'h8000_0000, 32'h1111_1111, 32'hFFFF_FFFF};
   int base, ra, rb, pb, hs0;

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();

      // Single request on requester 0.
      r0v = 1'b1; r0a = 32'd123; r0b = 32'd123; r0c = 1'b1;
      #1 chk("single_ready_same_cycle", {rdy0_1, rdy1_1}, 2'b10);
      tick();
      r0v = 1'b0;
      tick();
      chk("single_rsp0_pulse", {v0_1, v1_1}, 2'b10);
      chk("single_sum", {c0_1, s0_1}, {1'b0, 32'd247});

      // Overflow through requester 1.
      repeat (4) tick();
      r1v = 1'b1; r1a = 32'hFFFF_FFFF; r1b = 32'h0; r1c = 1'b1;
      tick();
      r1v = 1'b0;
      tick();
      chk("overflow_sum", {v1_1, c1_1, s1_1}, {1'b1, 1'b1, 32'h0});

      // Contention: pointer is back at requester 0.
      repeat (5) tick();
      base = q.size(); ra = rlog_a.size(); rb = rlog_b.size();
      r0v = 1'b1; r1v = 1'b1;
      for (int i = 0; i < 4; i++) begin
         r0a = tab_a[i]; r0b = tab_b[i]; r0c = i[0];
         r1a = tab_b[i]; r1b = ~tab_a[i]; r1c = ~i[0];
         tick();
      end
      r0v = 1'b0; r1v = 1'b0;
      repeat (6) tick();
      chk("contention_count", {q.size() - base, rlog_a.size() - ra, rlog_b.size() - rb}, {32'd4, 32'd4, 32'd4});
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("contention_grant%0d", i), q[base + i].tag, i % 2);
         chk($sformatf("contention_order_lat1_%0d", i), rlog_a[ra + i], i % 2);
         chk($sformatf("contention_order_lat3_%0d", i), rlog_b[rb + i], i % 2);
      end

      // Idle: nothing ready, pipelines drained.
      repeat (4) tick();
      chk("idle_state", {rdy0_1, rdy1_1, rdy0_3, rdy1_3, busy_1, busy_3, v0_3, v1_3}, 8'h00);

      // Back-to-back stream on requester 1.
      pb = plog.size();
      r1v = 1'b1;
      for (int i = 0; i < 8; i++) begin
         r1a = 32'd1000 * i + 32'd7; r1b = i; r1c = i[0];
         tick();
         if (i == 0) hs0 = cyc;
      end
      r1v = 1'b0;
      repeat (6) tick();
      chk("stream_count", plog.size() - pb, 8);
      if (plog.size() - pb >= 8) begin
         chk("stream_first_latency", plog[pb], hs0 + 3);
         for (int i = 1; i < 8; i++)
            chk($sformatf("stream_consecutive%0d", i), plog[pb + i] - plog[pb + i - 1], 1);
      end
      chk("stream_last_sum", {c1_3, s1_3}, {1'b0, 32'd7007 + 32'd7 + 32'd1});

      // Reset one cycle after a transfer.
      r0v = 1'b1; r0a = 32'd5; r0b = 32'd6; r0c = 1'b0;
      tick();
      r0v = 1'b0;
      tick();
      ra = rlog_a.size(); rb = rlog_b.size();
      rst_n = 1'b0;
      #1 chk("midreset_lat1_zero", o1, '0);
      chk("midreset_lat3_zero", o3, '0);
      tick();
      rst_n = 1'b1;
      r0v = 1'b1; r1v = 1'b1;
      #1 chk("post_reset_grant0", {rdy0_1, rdy1_1, rdy0_3, rdy1_3}, 4'b1010);
      tick();
      r0v = 1'b0; r1v = 1'b0;
      repeat (6) tick();
      chk("post_reset_rsp_count", {rlog_a.size() - ra, rlog_b.size() - rb}, {32'd1, 32'd1});
      if (rlog_a.size() > ra) chk("post_reset_rsp_tag", rlog_a[ra], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
